// File: rtl/logical_arbiter.sv
// Round-robin arbiter sharing one combinational logical unit between two issue ports,
// with a one-entry registered response buffer toward writeback.
module logical_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [3:0]       req0_funct_i,
  input  logic [31:0]      req0_op1_i,
  input  logic [31:0]      req0_op2_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic [3:0]       req1_funct_i,
  input  logic [31:0]      req1_op1_i,
  input  logic [31:0]      req1_op2_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic [3:0]       lu_funct_o,
  output logic [31:0]      lu_op1_o,
  output logic [31:0]      lu_op2_o,
  input  logic [31:0]      lu_res_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_src_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [CNT_W-1:0] ops_cnt_o
);

  localparam logic IDLE = 1'b0;
  localparam logic FULL = 1'b1;

  logic             state_reg;
  logic             prio_reg;
  logic [31:0]      rsp_data_reg;
  logic             rsp_src_reg;
  logic [TAG_W-1:0] rsp_tag_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             can_accept;
  logic             grant_valid;
  logic             grant_idx;
  logic [TAG_W-1:0] grant_tag;

  // The buffer can take a new result when empty, or when its current result leaves this cycle.
  assign can_accept = (state_reg == IDLE) | rsp_ready_i;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (can_accept) begin
      if (&req_valid_i) begin
        grant_valid = 1'b1;
        grant_idx   = prio_reg;
      end else if (req_valid_i[0]) begin
        grant_valid = 1'b1;
        grant_idx   = 1'b0;
      end else if (req_valid_i[1]) begin
        grant_valid = 1'b1;
        grant_idx   = 1'b1;
      end
    end
  end

  assign req_ready_o = {grant_valid & grant_idx, grant_valid & ~grant_idx};

  always_comb begin
    lu_funct_o = 4'd0;
    lu_op1_o   = 32'd0;
    lu_op2_o   = 32'd0;
    grant_tag  = '0;
    if (grant_valid) begin
      if (grant_idx) begin
        lu_funct_o = req1_funct_i;
        lu_op1_o   = req1_op1_i;
        lu_op2_o   = req1_op2_i;
        grant_tag  = req1_tag_i;
      end else begin
        lu_funct_o = req0_funct_i;
        lu_op1_o   = req0_op1_i;
        lu_op2_o   = req0_op2_i;
        grant_tag  = req0_tag_i;
      end
    end
  end

  // A grant is always a handshake, since ready is only raised for a valid port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      prio_reg     <= 1'b0;
      rsp_data_reg <= 32'd0;
      rsp_src_reg  <= 1'b0;
      rsp_tag_reg  <= '0;
    end else if (grant_valid) begin
      state_reg    <= FULL;
      prio_reg     <= ~grant_idx;
      rsp_data_reg <= lu_res_i;
      rsp_src_reg  <= grant_idx;
      rsp_tag_reg  <= grant_tag;
    end else if ((state_reg == FULL) && rsp_ready_i) begin
      state_reg <= IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_reg <= '0;
    end else if (rsp_valid_o && rsp_ready_i) begin
      cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rsp_valid_o = (state_reg == FULL);
  assign rsp_data_o  = rsp_data_reg;
  assign rsp_src_o   = rsp_src_reg;
  assign rsp_tag_o   = rsp_tag_reg;
  assign ops_cnt_o   = cnt_reg;

endmodule
